serial_mac_accumulator: RTL and testbench
=========================================

# serial_mac_accumulator

Bit-serial accumulation stage downstream of the signed population-count adder in the serial MAC datapath. Each cycle it takes one bit-plane partial sum (popcount of one weight bit ANDed across M activation lanes, negated for the weight MSB plane) and folds it into a two's-complement dot-product result by Horner shift-and-add, MSB plane first. It also sequences the bit index and the MSB flag that drive the adder and the upstream bit selector, then presents the finished result with a one-cycle done pulse.

## Interface
- M, 16: number of lanes reduced per plane by the adder.
- N, 8: weight bit width; also the number of planes per operation.
- PS_W (localparam), $clog2(M)+1: partial-sum input width.
- ACC_W (localparam), $clog2(M)+N: result width.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; accepted only in IDLE.
- valid_in  input  1  partial_in is valid this cycle.
- partial_in  input  PS_W  adder output for the current plane.
- msb_out  output  1  high while the current plane is N-1; drives the adder's MSB flag.
- bit_sel  output  $clog2(N)  current plane index, N-1 down to 0; selects the weight bit upstream.
- busy  output  1  high in ACCUM.
- done  output  1  one-cycle pulse; result is final.
- result  output  ACC_W  signed dot product; held until the next accepted start.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE: start=1 moves to ACCUM. On entry: acc=0, bit_sel=N-1.
- ACCUM: a plane is consumed only when valid_in=1; valid_in=0 stalls all state.
- Operand decode: if msb_out=1, partial_in is sign-extended, range -M..0. Otherwise it is zero-extended, range 0..M. The pattern 10000 (M=16) therefore means -16 on the MSB plane and +16 on other planes.
- Update per consumed plane: acc = (acc <<< 1) + ext(partial_in). The first plane therefore yields acc = ext(partial_in).
- On consuming plane 0: result <= final acc, move to DONE. Otherwise bit_sel decrements.
- DONE: done=1 for exactly one cycle, then return to IDLE. result stays unchanged.
- start while in ACCUM or DONE is ignored.
- No overflow is possible with the given ACC_W. Range is -M·2^(N-1) .. M·(2^(N-1)-1).

## Timing
- Reset values (rst=1 at an edge): state IDLE, result 0, done 0, busy 0, msb_out 0, bit_sel N-1, acc 0.
- Reset overrides every other input, including mid-ACCUM. The partial operation is discarded and no done is issued.
- Start accepted at edge t:
  - busy=1, msb_out=1 and bit_sel=N-1 are visible after edge t.
  - msb_out and bit_sel are registered outputs, so upstream has a full cycle to form the plane.
- With no stalls, the N planes are consumed at edges t+1..t+N.
- done=1 and the new result are visible after edge t+N, in the same cycle.
- Total latency is N+1 cycles from start to the done cycle. It extends by one cycle for each valid_in=0 cycle during ACCUM.
- busy drops in the DONE cycle.
- The earliest back-to-back start is accepted at edge t+N+2, i.e. in the IDLE cycle after done.
- valid_in is ignored outside ACCUM.

## Structure
- Shared package smac_pkg holds:
  - typedef enum state_t {IDLE, ACCUM, DONE};
  - width helper functions for PS_W and ACC_W, shared with the adder and the upstream selector.
- No sub-module. The FSM, plane counter and shift-accumulator are one always_ff block plus a combinational operand-extension block.

## Test plan
All scenarios use M=16, N=8.
- Weight -3 (11111101), all activations 1:
  - partials in order 16,16,16,16,16,16,0,16, no stalls;
  - done 9 cycles after start, result=-48;
  - msb_out high only in the first ACCUM cycle.
- Extremes:
  - weight -128: partials 16,0,0,0,0,0,0,0 -> result=-2048;
  - weight 127: partials 0,16,16,16,16,16,16,16 -> result=2032;
  - all-zero partials -> result=0.
- Stalls: the -3 case with valid_in low for 2 cycles after plane 5 and 1 cycle after plane 2 -> result=-48, done 12 cycles after start; bit_sel holds during stalls.
- start asserted continuously through an operation -> only one operation runs. The next start is accepted in the IDLE cycle after done; result holds -48 until the second operation completes.
- rst asserted at the 4th ACCUM cycle:
  - next cycle shows state IDLE, result=0, busy=0, bit_sel=7, and no done pulse;
  - a fresh operation then completes correctly.
- Random weights and activations (1000 runs, random stalls) vs a reference model computing Σ a·b_i with signed a and b_i ∈ {0,1} -> exact match.

Source files
------------

// File: rtl/smac_pkg.sv
// Shared definitions for the serial MAC datapath: accumulator state encoding
// and the width helpers used by the adder, the bit selector and the accumulator.
package smac_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   // Partial-sum width: a popcount of M lanes (0..M) plus a sign bit,
   // so the negated MSB plane (-M..0) fits as well.
   function automatic int ps_width(input int m);
      return $clog2(m) + 1;
   endfunction

   // Result width: enough for -M*2^(N-1) .. M*(2^(N-1)-1).
   function automatic int acc_width(input int m, input int n);
      return $clog2(m) + n;
   endfunction

endpackage

// File: rtl/serial_mac_accumulator.sv
// Bit-serial Horner accumulator: folds one signed bit-plane partial sum per
// consumed cycle (MSB plane first) into a two's-complement dot product, and
// sequences the plane index / MSB flag for the adder and weight-bit selector.
module serial_mac_accumulator
   import smac_pkg::*;
#(
   parameter  int M     = 16,
   parameter  int N     = 8,
   localparam int PS_W  = ps_width(M),
   localparam int ACC_W = acc_width(M, N),
   localparam int BS_W  = $clog2(N)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    valid_in,
   input  logic [PS_W-1:0]         partial_in,
   output logic                    msb_out,
   output logic [BS_W-1:0]         bit_sel,
   output logic                    busy,
   output logic                    done,
   output logic signed [ACC_W-1:0] result
);

   localparam logic [BS_W-1:0] TOP_PLANE = BS_W'(N - 1);

   state_t                  state;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] operand;
   logic signed [ACC_W-1:0] acc_next;

   // Operand decode (MSB plane is negative, others are plain counts) and the Horner step.
   always_comb begin
      // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
      operand = {{(ACC_W - PS_W){1'b0}}, partial_in};
      if (msb_out) begin
         operand = {{(ACC_W - PS_W){partial_in[PS_W-1]}}, partial_in};
      end
      acc_next = (acc <<< 1) + operand;
   end

   // FSM, plane counter, accumulator and registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         result  <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
         msb_out <= 1'b0;
         bit_sel <= TOP_PLANE;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state   <= ACCUM;
                  acc     <= '0;
                  bit_sel <= TOP_PLANE;
                  msb_out <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            ACCUM: begin
               // valid_in low freezes every register, so upstream can stall freely.
               if (valid_in) begin
                  acc     <= acc_next;
                  msb_out <= 1'b0;
                  if (bit_sel == '0) begin
                     result <= acc_next;
                     done   <= 1'b1;
                     busy   <= 1'b0;
                     state  <= DONE;
                  end else begin
                     bit_sel <= bit_sel - 1'b1;
                  end
               end
            end
            DONE: begin
               // start is deliberately ignored here; the earliest restart is from IDLE.
               state   <= IDLE;
               acc     <= '0;
               bit_sel <= TOP_PLANE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mac_accumulator.sv
// Self-checking bench for serial_mac_accumulator (M=16, N=8): directed table
// of uniform-weight cases, stall / held-start / reset sequences, and random
// lane weights and activations checked against a plain dot-product model.
module tb_serial_mac_accumulator;

   localparam int M = 16;
   localparam int N = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               valid_in;
   logic [4:0]         partial_in;
   logic               msb_out;
   logic [2:0]         bit_sel;
   logic               busy;
   logic               done;
   logic signed [11:0] result;

   int tests = 0;
   int fails = 0;

   // Current operation: partials in consumption order (index 0 = plane N-1),
   // stall cycles inserted before each plane, and the model's expected result.
   logic [4:0] cur_p [N];
   int         cur_stall [N];
   int         cur_exp;
   int         last_res;

   typedef struct {
      string             name;
      logic signed [7:0] w;
      int                act;
      int                exp;
   } vec_t;

   vec_t vecs [6];

   serial_mac_accumulator #(.M(M), .N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .valid_in   (valid_in),
      .partial_in (partial_in),
      .msb_out    (msb_out),
      .bit_sel    (bit_sel),
      .busy       (busy),
      .done       (done),
      .result     (result)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic signed [31:0] actual,
                        input logic signed [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Advance one edge; outputs are sampled 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // All M lanes share weight w; the first act lanes have activation 1.
   task automatic load_uniform(input logic signed [7:0] w, input int act);
      int pc;
      for (int k = 0; k < N; k++) begin
         pc = w[N-1-k] ? act : 0;
         cur_p[k]     = (k == 0) ? 5'(-pc) : 5'(pc);
         cur_stall[k] = 0;
      end
   endtask

   // Independent random lane weights and activation bits; expected value is
   // the plain dot product, partials are the adder's per-plane popcounts.
   task automatic load_random();
      logic signed [7:0] w [M];
      logic              a [M];
      int                pc;
      cur_exp = 0;
      for (int j = 0; j < M; j++) begin
         w[j] = 8'($urandom);
         a[j] = 1'($urandom);
         if (a[j]) cur_exp += int'(w[j]);
      end
      for (int k = 0; k < N; k++) begin
         pc = 0;
         for (int j = 0; j < M; j++) if (a[j] && w[j][N-1-k]) pc++;
         cur_p[k]     = (k == 0) ? 5'(-pc) : 5'(pc);
         cur_stall[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      end
   endtask

   // One operation from IDLE; checks handshake outputs every cycle and the
   // exact cycle done appears. With hold set, start stays high throughout.
   task automatic run_op(input string tag, input bit hold);
      start      = 1'b1;
      valid_in   = 1'b0;
      partial_in = 5'($urandom);
      step();
      check({tag, " accept busy"}, busy, 1);
      check({tag, " accept msb_out"}, msb_out, 1);
      check({tag, " accept bit_sel"}, bit_sel, N - 1);
      check({tag, " result held until done"}, result, last_res);
      if (!hold) start = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int s = 0; s < cur_stall[k]; s++) begin
            valid_in   = 1'b0;
            partial_in = 5'($urandom);
            step();
            check({tag, " stall bit_sel"}, bit_sel, N - 1 - k);
            check({tag, " stall msb_out"}, msb_out, (k == 0) ? 1 : 0);
         end
         check({tag, " plane bit_sel"}, bit_sel, N - 1 - k);
         check({tag, " plane msb_out"}, msb_out, (k == 0) ? 1 : 0);
         check({tag, " early done"}, done, 0);
         check({tag, " plane busy"}, busy, 1);
         valid_in   = 1'b1;
         partial_in = cur_p[k];
         step();
      end
      valid_in = 1'b0;
      check({tag, " done on time"}, done, 1);
      check({tag, " result"}, result, cur_exp);
      check({tag, " busy in done cycle"}, busy, 0);
      step();
      check({tag, " done pulse width"}, done, 0);
      check({tag, " idle busy"}, busy, 0);
      check({tag, " result holds"}, result, cur_exp);
      last_res = cur_exp;
   endtask

   initial begin
      vecs[0] = '{"w=-3",       -8'sd3,   16,   -48};
      vecs[1] = '{"w=-128",     -8'sd128, 16, -2048};
      vecs[2] = '{"w=127",       8'sd127, 16,  2032};
      vecs[3] = '{"w=0",         8'sd0,   16,     0};
      vecs[4] = '{"w=5 act=3",   8'sd5,    3,    15};
      vecs[5] = '{"w=-1 act=7", -8'sd1,    7,    -7};

      rst        = 1'b1;
      start      = 1'b1;
      valid_in   = 1'b1;
      partial_in = 5'h1f;
      last_res   = 0;
      step();
      step();
      check("reset result", result, 0);
      check("reset done", done, 0);
      check("reset busy", busy, 0);
      check("reset msb_out", msb_out, 0);
      check("reset bit_sel", bit_sel, N - 1);
      rst      = 1'b0;
      start    = 1'b0;
      valid_in = 1'b0;
      step();

      // Directed uniform-weight table.
      for (int v = 0; v < 6; v++) begin
         load_uniform(vecs[v].w, vecs[v].act);
         cur_exp = vecs[v].exp;
         run_op(vecs[v].name, 1'b0);
      end

      // Stalls: 2 cycles before plane 4, 1 cycle before plane 1.
      load_uniform(-8'sd3, 16);
      cur_exp      = -48;
      cur_stall[3] = 2;
      cur_stall[6] = 1;
      run_op("stall -3", 1'b0);

      // Start held high: one op, then the next accepted straight after done.
      load_uniform(-8'sd3, 16);
      cur_exp = -48;
      run_op("held start op1", 1'b1);
      load_uniform(8'sd127, 16);
      cur_exp = 2032;
      run_op("held start op2", 1'b0);

      // Reset in the 4th ACCUM cycle discards the operation.
      load_uniform(-8'sd3, 16);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         valid_in   = 1'b1;
         partial_in = cur_p[k];
         step();
      end
      rst        = 1'b1;
      partial_in = cur_p[3];
      step();
      rst      = 1'b0;
      valid_in = 1'b0;
      check("mid reset busy", busy, 0);
      check("mid reset result", result, 0);
      check("mid reset bit_sel", bit_sel, N - 1);
      check("mid reset msb_out", msb_out, 0);
      check("mid reset done", done, 0);
      for (int i = 0; i < 10; i++) begin
         valid_in   = 1'b1;
         partial_in = 5'($urandom);
         step();
         check("post reset no done", done, 0);
         check("post reset idle", busy, 0);
      end
      last_res = 0;
      cur_exp  = -48;
      run_op("after reset", 1'b0);

      // Random lanes and stalls, with ignored valid_in traffic between ops.
      for (int r = 0; r < 1000; r++) begin
         load_random();
         run_op($sformatf("rand %0d", r), 1'b0);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            valid_in   = 1'($urandom);
            partial_in = 5'($urandom);
            step();
            check("idle ignores valid_in", busy, 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
